// File: rtl/rdyval_arb2reqack_tph_if.sv
// rtl/rdyval_arb2reqack_tph_if.sv - bundle of requester-side ready/valid and two-phase req/ack signals
//
// Purpose: groups the arbiter's handshake and data signals so a whole
//          requester/converter connection passes through a single port.
// Ports (as seen by the arbiter through the slave modport):
//   vld   in   NREQ         per-requester valid
//   rdy   out  NREQ         per-requester ready, one-hot or zero
//   i_dat in   NREQ*DWIDTH  requester data, slice i at [i*DWIDTH +: DWIDTH]
//   req   out  1            two-phase request, toggles once per transfer
//   ack   in   1            two-phase acknowledge from the receiver
//   o_dat out  DWIDTH       registered data of the current transfer
//   o_id  out  IDW          registered index of the owning requester
//   busy  out  1            transfer outstanding
//   err   out  1            sticky protocol error
interface rdyval_arb2reqack_tph_if #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 1
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]        vld;
  logic [NREQ-1:0]        rdy;
  logic [NREQ*DWIDTH-1:0] i_dat;
  logic                   req;
  logic                   ack;
  logic [DWIDTH-1:0]      o_dat;
  logic [IDW-1:0]         o_id;
  logic                   busy;
  logic                   err;

  modport master (
    output vld, i_dat, ack,
    input  rdy, req, o_dat, o_id, busy, err
  );

  modport slave (
    input  vld, i_dat, ack,
    output rdy, req, o_dat, o_id, busy, err
  );
endinterface

// File: rtl/rdyval_arb2reqack_tph.sv
// rtl/rdyval_arb2reqack_tph.sv - round-robin arbiter from N ready/valid requesters onto a two-phase req/ack link
//
// Purpose: picks one valid requester at a time (round-robin starting after
//          the last winner), latches its data and index, toggles req, and
//          waits for the two-phase ack before granting again.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of rdyval_arb2reqack_tph_if (vld/rdy/i_dat,
//          req/ack, o_dat/o_id, busy, err)
module rdyval_arb2reqack_tph #(
  parameter int NREQ        = 4,
  parameter int DWIDTH      = 1,
  parameter bit INCLUDE_CDC = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rdyval_arb2reqack_tph_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]        state;
  logic              req_q;
  logic              ack_i;
  logic              ack_q;
  logic              err_q;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    o_id_q;
  logic [DWIDTH-1:0] o_dat_q;

  logic              win_found;
  logic [IDW-1:0]    win_idx;
  logic [NREQ-1:0]   rdy_c;
  logic              grant;
  int                cand;

  // Receiver-side ack, optionally resynchronized into this clock domain.
  generate
    if (INCLUDE_CDC) begin : g_cdc
      logic sync1;
      logic sync2;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync1 <= 1'b0;
          sync2 <= 1'b0;
        end else begin
          sync1 <= bus.ack;
          sync2 <= sync1;
        end
      end
      assign ack_i = sync2;
    end else begin : g_nocdc
      assign ack_i = bus.ack;
    end
  endgenerate

  // Round-robin search: candidates ptr+1, ptr+2, ... wrapping, ptr itself last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      if (!win_found && bus.vld[cand]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  // Ready is suppressed during reset so no requester sees a phantom handshake.
  assign grant = (state == ST_IDLE) && win_found && rst_n;

  always_comb begin
    rdy_c = '0;
    if (grant) begin
      rdy_c[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      req_q   <= 1'b0;
      ptr     <= IDW'(NREQ - 1);
      o_dat_q <= '0;
      o_id_q  <= '0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= ack_i;
      // Any ack movement while nothing is outstanding is a protocol error;
      // it is only flagged, the FSM keeps running.
      if ((state == ST_IDLE) && (ack_i != ack_q)) begin
        err_q <= 1'b1;
      end
      if (state == ST_IDLE) begin
        if (win_found) begin
          o_dat_q <= bus.i_dat[win_idx*DWIDTH +: DWIDTH];
          o_id_q  <= win_idx;
          ptr     <= win_idx;
          req_q   <= ~req_q;
          state   <= ST_WAIT;
        end
      end else begin
        if (ack_i == req_q) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  assign bus.rdy   = rdy_c;
  assign bus.req   = req_q;
  assign bus.o_dat = o_dat_q;
  assign bus.o_id  = o_id_q;
  assign bus.busy  = (state == ST_WAIT);
  assign bus.err   = err_q;
endmodule

// File: tb/tb_rdyval_arb2reqack_tph.sv
// tb/tb_rdyval_arb2reqack_tph.sv - directed self-checking bench for rdyval_arb2reqack_tph
module tb_rdyval_arb2reqack_tph;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rdyval_arb2reqack_tph_if #(.NREQ(4), .DWIDTH(8)) if0 ();
  rdyval_arb2reqack_tph_if #(.NREQ(4), .DWIDTH(8)) if1 ();

  rdyval_arb2reqack_tph #(.NREQ(4), .DWIDTH(8), .INCLUDE_CDC(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave)
  );
  rdyval_arb2reqack_tph #(.NREQ(4), .DWIDTH(8), .INCLUDE_CDC(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if0.vld = '0; if0.ack = 1'b0; if0.i_dat = '0;
    if1.vld = '0; if1.ack = 1'b0; if1.i_dat = '0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if0.vld = 4'b1111; if0.ack = 1'b0; if0.i_dat = 32'h11223344;
    if1.vld = 4'b1111; if1.ack = 1'b0; if1.i_dat = 32'h11223344;
    step(); step();
    #1;
    total++; if (if0.rdy !== 4'b0000) begin bad++; $display("FAIL reset_rdy got=%b exp=0000", if0.rdy); end
    total++; if (if0.req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", if0.req); end
    total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", if0.busy); end
    total++; if (if0.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", if0.err); end
    total++; if (if0.o_dat !== 8'h00 || if0.o_id !== 2'd0) begin bad++; $display("FAIL reset_out got=%h/%0d exp=00/0", if0.o_dat, if0.o_id); end
    total++; if (if1.rdy !== 4'b0000 || if1.busy !== 1'b0 || if1.req !== 1'b0) begin bad++; $display("FAIL reset_cdc got=%b/%b/%b exp=0000/0/0", if1.rdy, if1.busy, if1.req); end
    if0.vld = '0; if1.vld = '0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    do_reset();
    if0.i_dat = {8'h44, 8'hA5, 8'h22, 8'h11};
    if0.vld = 4'b0100;
    #1;
    total++; if (if0.rdy !== 4'b0100) begin bad++; $display("FAIL single_rdy got=%b exp=0100", if0.rdy); end
    step();
    if0.vld = 4'b0000;
    #1;
    total++; if (if0.req !== 1'b1) begin bad++; $display("FAIL single_req got=%b exp=1", if0.req); end
    total++; if (if0.o_dat !== 8'hA5) begin bad++; $display("FAIL single_dat got=%h exp=a5", if0.o_dat); end
    total++; if (if0.o_id !== 2'd2) begin bad++; $display("FAIL single_id got=%0d exp=2", if0.o_id); end
    total++; if (if0.busy !== 1'b1 || if0.rdy !== 4'b0000) begin bad++; $display("FAIL single_wait got=%b/%b exp=1/0000", if0.busy, if0.rdy); end
    if0.ack = 1'b1;
    step();
    #1;
    total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL single_done got=%b exp=0", if0.busy); end
    total++; if (if0.err !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", if0.err); end
  endtask

  task automatic test_fairness();
    logic [7:0] e_dat;
    logic [3:0] e_rdy;
    do_reset();
    if0.i_dat = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    if0.vld = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      e_rdy = 4'b0001 << (i % 4);
      total++; if (if0.rdy !== e_rdy) begin bad++; $display("FAIL fair_rdy[%0d] got=%b exp=%b", i, if0.rdy, e_rdy); end
      step();
      #1;
      e_dat = 8'hA0 + 8'(17 * (i % 4));
      total++; if (if0.o_id !== 2'(i % 4)) begin bad++; $display("FAIL fair_id[%0d] got=%0d exp=%0d", i, if0.o_id, i % 4); end
      total++; if (if0.o_dat !== e_dat) begin bad++; $display("FAIL fair_dat[%0d] got=%h exp=%h", i, if0.o_dat, e_dat); end
      total++; if (if0.req !== 1'((i + 1) % 2) || if0.busy !== 1'b1) begin bad++; $display("FAIL fair_req[%0d] got=%b/%b exp=%0d/1", i, if0.req, if0.busy, (i + 1) % 2); end
      if0.ack = if0.req;
      step();
      #1;
      total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL fair_period[%0d] got=%b exp=0", i, if0.busy); end
    end
    if0.vld = '0;
  endtask

  task automatic test_skip();
    logic [1:0] e_id;
    do_reset();
    if0.i_dat = {8'h03, 8'h02, 8'h01, 8'h00};
    if0.vld = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      e_id = (i % 2 == 0) ? 2'd1 : 2'd3;
      step();
      #1;
      total++; if (if0.o_id !== e_id || if0.o_dat !== {6'd0, e_id}) begin bad++; $display("FAIL skip_id[%0d] got=%0d/%h exp=%0d", i, if0.o_id, if0.o_dat, e_id); end
      if0.ack = if0.req;
      step();
    end
    if0.vld = '0;
  endtask

  task automatic test_drop();
    do_reset();
    if0.vld = 4'b0100;
    #1;
    total++; if (if0.rdy !== 4'b0100) begin bad++; $display("FAIL drop_rdy0 got=%b exp=0100", if0.rdy); end
    if0.vld = 4'b0000;
    step();
    #1;
    total++; if (if0.busy !== 1'b0 || if0.err !== 1'b0 || if0.req !== 1'b0) begin bad++; $display("FAIL drop_idle got=%b/%b/%b exp=0/0/0", if0.busy, if0.err, if0.req); end
    if0.vld = 4'b0011;
    #1;
    total++; if (if0.rdy !== 4'b0001) begin bad++; $display("FAIL drop_ptr got=%b exp=0001", if0.rdy); end
    if0.vld = '0;
  endtask

  task automatic test_cdc();
    int         nbusy;
    logic [7:0] held;
    do_reset();
    if1.i_dat = {8'h5A, 8'h77, 8'h66, 8'h55};
    for (int t = 0; t < 2; t++) begin
      if1.vld = (t == 0) ? 4'b0100 : 4'b1000;
      step();
      if1.vld = '0;
      #1;
      held  = if1.o_dat;
      nbusy = 0;
      total++; if (held !== ((t == 0) ? 8'h77 : 8'h5A)) begin bad++; $display("FAIL cdc_dat[%0d] got=%h", t, held); end
      for (int c = 0; c < 10 && if1.busy === 1'b1; c++) begin
        nbusy++;
        if1.ack = if1.req;
        if (if1.o_dat !== held) begin total++; bad++; $display("FAIL cdc_stable[%0d] got=%h exp=%h", t, if1.o_dat, held); end
        step();
        #1;
      end
      total++; if (nbusy != 3) begin bad++; $display("FAIL cdc_busy[%0d] got=%0d exp=3", t, nbusy); end
    end
    step();
    #1;
    total++; if (if1.err !== 1'b0) begin bad++; $display("FAIL cdc_err got=%b exp=0", if1.err); end
  endtask

  task automatic test_error();
    do_reset();
    #1;
    total++; if (if0.err !== 1'b0) begin bad++; $display("FAIL err_pre got=%b exp=0", if0.err); end
    if0.ack = 1'b1;
    step();
    #1;
    total++; if (if0.err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", if0.err); end
    step();
    #1;
    total++; if (if0.err !== 1'b1) begin bad++; $display("FAIL err_hold got=%b exp=1", if0.err); end
    if0.vld = 4'b0001;
    step();
    if0.vld = '0;
    #1;
    total++; if (if0.req !== 1'b1 || if0.busy !== 1'b1) begin bad++; $display("FAIL err_grant got=%b/%b exp=1/1", if0.req, if0.busy); end
    step();
    #1;
    total++; if (if0.busy !== 1'b0 || if0.err !== 1'b1) begin bad++; $display("FAIL err_after got=%b/%b exp=0/1", if0.busy, if0.err); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    if0.vld = 4'b0100;
    step();
    if0.vld = '0;
    #1;
    total++; if (if0.busy !== 1'b1) begin bad++; $display("FAIL midrst_wait got=%b exp=1", if0.busy); end
    rst_n = 1'b0;
    if0.vld = 4'b1111;
    #1;
    total++; if (if0.rdy !== 4'b0000) begin bad++; $display("FAIL midrst_rdy got=%b exp=0000", if0.rdy); end
    step();
    #1;
    total++; if (if0.req !== 1'b0 || if0.busy !== 1'b0) begin bad++; $display("FAIL midrst_state got=%b/%b exp=0/0", if0.req, if0.busy); end
    rst_n = 1'b1;
    #1;
    total++; if (if0.rdy !== 4'b0001) begin bad++; $display("FAIL midrst_rdy0 got=%b exp=0001", if0.rdy); end
    step();
    #1;
    total++; if (if0.o_id !== 2'd0 || if0.req !== 1'b1) begin bad++; $display("FAIL midrst_first got=%0d/%b exp=0/1", if0.o_id, if0.req); end
    if0.vld = '0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    if0.vld = '0; if0.ack = 1'b0; if0.i_dat = '0;
    if1.vld = '0; if1.ack = 1'b0; if1.i_dat = '0;
    test_reset();
    test_single();
    test_fairness();
    test_skip();
    test_drop();
    test_cdc();
    test_error();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
